// File: rtl/axi_lite_arbiter_2to1.sv
// axi_lite_arbiter_2to1
//   Arbitrates two AXI4-Lite masters (slave ports s0/s1) onto one shared
//   AXI4-Lite slave (master port m). One transaction is in flight at a time.
//   Contended IDLE cycles are resolved round-robin against the last grant.
//   Within one port, a write (AW+W both valid) wins over a read.
//
// Ports
//   aclk, areset      : clock, synchronous active-high reset
//   sN_axi_aw*/w*/b*  : write address/data/response channels of slave port N
//   sN_axi_ar*/r*     : read address/data channels of slave port N
//   m_axi_*           : mirrored channel set towards the shared slave
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    // slave port 0
    input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
    input  logic [2:0]            s0_axi_awprot,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [31:0]           s0_axi_wdata,
    input  logic [3:0]            s0_axi_wstrb,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic [1:0]            s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [2:0]            s0_axi_arprot,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [31:0]           s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    // slave port 1
    input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
    input  logic [2:0]            s1_axi_awprot,
    input  logic                  s1_axi_awvalid,
    output logic                  s1_axi_awready,
    input  logic [31:0]           s1_axi_wdata,
    input  logic [3:0]            s1_axi_wstrb,
    input  logic                  s1_axi_wvalid,
    output logic                  s1_axi_wready,
    output logic [1:0]            s1_axi_bresp,
    output logic                  s1_axi_bvalid,
    input  logic                  s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [2:0]            s1_axi_arprot,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [31:0]           s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    // master port
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RD,
        RR
    } state_t;

    state_t r_state, w_state_nxt;
    logic   r_g, w_g_nxt;
    logic   r_lg, w_lg_nxt;
    logic   r_aw_done, w_aw_done_nxt;
    logic   r_w_done, w_w_done_nxt;

    logic   w_wr0, w_wr1, w_req0, w_req1, w_pick;
    logic   w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;

    assign w_wr0  = s0_axi_awvalid & s0_axi_wvalid;
    assign w_wr1  = s1_axi_awvalid & s1_axi_wvalid;
    assign w_req0 = w_wr0 | s0_axi_arvalid;
    assign w_req1 = w_wr1 | s1_axi_arvalid;
    // Under contention the port that did not win last time is chosen.
    assign w_pick = (w_req0 && w_req1) ? ~r_lg : w_req1;

    assign w_aw_hs  = m_axi_awvalid & m_axi_awready;
    assign w_w_hs   = m_axi_wvalid & m_axi_wready;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= IDLE;
            r_g       <= 1'b0;
            r_lg      <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_g       <= w_g_nxt;
            r_lg      <= w_lg_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_g_nxt       = r_g;
        w_lg_nxt      = r_lg;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            IDLE: begin
                if (w_req0 || w_req1) begin
                    w_g_nxt     = w_pick;
                    w_lg_nxt    = w_pick;
                    w_state_nxt = (w_pick ? w_wr1 : w_wr0) ? WR : RD;
                end
            end
            WR: begin
                if (w_aw_fin && w_w_fin) begin
                    w_state_nxt   = WB;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else begin
                    w_aw_done_nxt = w_aw_fin;
                    w_w_done_nxt  = w_w_fin;
                end
            end
            WB: if (m_axi_bvalid && m_axi_bready) w_state_nxt = IDLE;
            RD: if (m_axi_arvalid && m_axi_arready) w_state_nxt = RR;
            RR: if (m_axi_rvalid && m_axi_rready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Channel routing; everything not explicitly forwarded stays at 0.
    always_comb begin
        m_axi_awaddr   = '0;
        m_axi_awprot   = '0;
        m_axi_awvalid  = 1'b0;
        m_axi_wdata    = '0;
        m_axi_wstrb    = '0;
        m_axi_wvalid   = 1'b0;
        m_axi_bready   = 1'b0;
        m_axi_araddr   = '0;
        m_axi_arprot   = '0;
        m_axi_arvalid  = 1'b0;
        m_axi_rready   = 1'b0;
        s0_axi_awready = 1'b0;
        s0_axi_wready  = 1'b0;
        s0_axi_bresp   = '0;
        s0_axi_bvalid  = 1'b0;
        s0_axi_arready = 1'b0;
        s0_axi_rdata   = '0;
        s0_axi_rresp   = '0;
        s0_axi_rvalid  = 1'b0;
        s1_axi_awready = 1'b0;
        s1_axi_wready  = 1'b0;
        s1_axi_bresp   = '0;
        s1_axi_bvalid  = 1'b0;
        s1_axi_arready = 1'b0;
        s1_axi_rdata   = '0;
        s1_axi_rresp   = '0;
        s1_axi_rvalid  = 1'b0;
        case (r_state)
            WR: begin
                m_axi_awaddr = r_g ? s1_axi_awaddr : s0_axi_awaddr;
                m_axi_awprot = r_g ? s1_axi_awprot : s0_axi_awprot;
                m_axi_wdata  = r_g ? s1_axi_wdata  : s0_axi_wdata;
                m_axi_wstrb  = r_g ? s1_axi_wstrb  : s0_axi_wstrb;
                // A finished channel is masked on both sides so neither the
                // slave nor the master can see a second handshake on it.
                m_axi_awvalid = ~r_aw_done & (r_g ? s1_axi_awvalid : s0_axi_awvalid);
                m_axi_wvalid  = ~r_w_done  & (r_g ? s1_axi_wvalid  : s0_axi_wvalid);
                if (r_g) begin
                    s1_axi_awready = m_axi_awready & ~r_aw_done;
                    s1_axi_wready  = m_axi_wready  & ~r_w_done;
                end else begin
                    s0_axi_awready = m_axi_awready & ~r_aw_done;
                    s0_axi_wready  = m_axi_wready  & ~r_w_done;
                end
            end
            WB: begin
                m_axi_bready = r_g ? s1_axi_bready : s0_axi_bready;
                if (r_g) begin
                    s1_axi_bvalid = m_axi_bvalid;
                    s1_axi_bresp  = m_axi_bresp;
                end else begin
                    s0_axi_bvalid = m_axi_bvalid;
                    s0_axi_bresp  = m_axi_bresp;
                end
            end
            RD: begin
                m_axi_araddr  = r_g ? s1_axi_araddr  : s0_axi_araddr;
                m_axi_arprot  = r_g ? s1_axi_arprot  : s0_axi_arprot;
                m_axi_arvalid = r_g ? s1_axi_arvalid : s0_axi_arvalid;
                if (r_g) s1_axi_arready = m_axi_arready;
                else     s0_axi_arready = m_axi_arready;
            end
            RR: begin
                m_axi_rready = r_g ? s1_axi_rready : s0_axi_rready;
                if (r_g) begin
                    s1_axi_rvalid = m_axi_rvalid;
                    s1_axi_rdata  = m_axi_rdata;
                    s1_axi_rresp  = m_axi_rresp;
                end else begin
                    s0_axi_rvalid = m_axi_rvalid;
                    s0_axi_rdata  = m_axi_rdata;
                    s0_axi_rresp  = m_axi_rresp;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1. The shared slave is scripted
// step by step from the initial block; inputs change #1 after a rising edge
// and outputs are checked #1 later.
module tb_axi_lite_arbiter_2to1;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  s0_awaddr, s1_awaddr, s0_araddr, s1_araddr, m_awaddr, m_araddr;
    logic [2:0]  s0_awprot, s1_awprot, s0_arprot, s1_arprot, m_awprot, m_arprot;
    logic        s0_awvalid, s1_awvalid, s0_awready, s1_awready, m_awvalid, m_awready;
    logic [31:0] s0_wdata, s1_wdata, m_wdata, s0_rdata, s1_rdata, m_rdata;
    logic [3:0]  s0_wstrb, s1_wstrb, m_wstrb;
    logic        s0_wvalid, s1_wvalid, s0_wready, s1_wready, m_wvalid, m_wready;
    logic [1:0]  s0_bresp, s1_bresp, m_bresp, s0_rresp, s1_rresp, m_rresp;
    logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready, m_bvalid, m_bready;
    logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready, m_arvalid, m_arready;
    logic        s0_rvalid, s1_rvalid, s0_rready, s1_rready, m_rvalid, m_rready;

    int checks = 0;
    int failures = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt = 0;
    int aw_base, w_base;

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (m_awvalid && m_awready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (m_wvalid && m_wready)   w_hs_cnt  <= w_hs_cnt + 1;
    end

    axi_lite_arbiter_2to1 #(.ADDR_WIDTH(4)) dut (
        .aclk(aclk), .areset(areset),
        .s0_axi_awaddr(s0_awaddr), .s0_axi_awprot(s0_awprot), .s0_axi_awvalid(s0_awvalid),
        .s0_axi_awready(s0_awready), .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb),
        .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(s0_wready), .s0_axi_bresp(s0_bresp),
        .s0_axi_bvalid(s0_bvalid), .s0_axi_bready(s0_bready), .s0_axi_araddr(s0_araddr),
        .s0_axi_arprot(s0_arprot), .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(s0_arready),
        .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp), .s0_axi_rvalid(s0_rvalid),
        .s0_axi_rready(s0_rready),
        .s1_axi_awaddr(s1_awaddr), .s1_axi_awprot(s1_awprot), .s1_axi_awvalid(s1_awvalid),
        .s1_axi_awready(s1_awready), .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb),
        .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(s1_wready), .s1_axi_bresp(s1_bresp),
        .s1_axi_bvalid(s1_bvalid), .s1_axi_bready(s1_bready), .s1_axi_araddr(s1_araddr),
        .s1_axi_arprot(s1_arprot), .s1_axi_arvalid(s1_arvalid), .s1_axi_arready(s1_arready),
        .s1_axi_rdata(s1_rdata), .s1_axi_rresp(s1_rresp), .s1_axi_rvalid(s1_rvalid),
        .s1_axi_rready(s1_rready),
        .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
        .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_araddr(m_araddr),
        .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid),
        .m_axi_rready(m_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        areset = 1'b1;
        s0_awaddr = '0; s0_awprot = '0; s0_awvalid = 0; s0_wdata = '0; s0_wstrb = '0;
        s0_wvalid = 0; s0_bready = 0; s0_araddr = '0; s0_arprot = '0; s0_arvalid = 0; s0_rready = 0;
        s1_awaddr = '0; s1_awprot = '0; s1_awvalid = 0; s1_wdata = '0; s1_wstrb = '0;
        s1_wvalid = 0; s1_bready = 0; s1_araddr = '0; s1_arprot = '0; s1_arvalid = 0; s1_rready = 0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;

        // ---- reset state
        tick(); tick();
        settle();
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_wvalid", m_wvalid, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_bready", m_bready, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_s0_awready", s0_awready, 0);
        chk("rst_s1_rvalid", s1_rvalid, 0);
        areset = 1'b0;

        // ---- single write from port 0
        tick();
        s0_awaddr = 4'h0; s0_awprot = 3'h2; s0_awvalid = 1;
        s0_wdata = 32'hA5; s0_wstrb = 4'hF; s0_wvalid = 1;
        settle();
        chk("wr_idle_no_fwd", m_awvalid, 0);
        tick();
        chk("wr_m_awvalid", m_awvalid, 1);
        chk("wr_m_awaddr", m_awaddr, 4'h0);
        chk("wr_m_awprot", m_awprot, 3'h2);
        chk("wr_m_wdata", m_wdata, 32'hA5);
        chk("wr_m_wstrb", m_wstrb, 4'hF);
        m_awready = 1; m_wready = 1;
        settle();
        chk("wr_s0_awready", s0_awready, 1);
        chk("wr_s0_wready", s0_wready, 1);
        chk("wr_s1_awready", s1_awready, 0);
        tick();
        s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = 2'b00; s0_bready = 1;
        settle();
        chk("wr_s0_bvalid", s0_bvalid, 1);
        chk("wr_s0_bresp", s0_bresp, 0);
        chk("wr_m_bready", m_bready, 1);
        chk("wr_s1_bvalid", s1_bvalid, 0);
        tick();
        m_bvalid = 0; s0_bready = 0;
        settle();
        chk("wr_done_idle", s0_bvalid, 0);

        // ---- contended reads right after reset: grants 0,1,0,1
        areset = 1;
        tick();
        areset = 0;
        s0_araddr = 4'h4; s1_araddr = 4'h8;
        for (int r = 0; r < 4; r++) begin
            s0_arvalid = 1; s1_arvalid = 1;
            tick();
            m_arready = 1;
            settle();
            chk("rr_s0_arready", s0_arready, (r % 2 == 0) ? 1 : 0);
            chk("rr_s1_arready", s1_arready, (r % 2 == 1) ? 1 : 0);
            chk("rr_m_araddr", m_araddr, (r % 2 == 0) ? 4'h4 : 4'h8);
            tick();
            m_arready = 0;
            m_rvalid = 1; m_rdata = 32'h1000_0000 + r; m_rresp = 2'b10;
            if (r % 2 == 0) begin s0_arvalid = 0; s0_rready = 1; end
            else            begin s1_arvalid = 0; s1_rready = 1; end
            settle();
            if (r % 2 == 0) begin
                chk("rr_s0_rdata", s0_rdata, 32'h1000_0000 + r);
                chk("rr_s0_rresp_slverr", s0_rresp, 2'b10);
                chk("rr_s1_rvalid_idle", s1_rvalid, 0);
            end else begin
                chk("rr_s1_rdata", s1_rdata, 32'h1000_0000 + r);
                chk("rr_s0_rvalid_idle", s0_rvalid, 0);
            end
            chk("rr_m_rready", m_rready, 1);
            tick();
            m_rvalid = 0; s0_rready = 0; s1_rready = 0;
        end
        s0_arvalid = 0;

        // ---- port 1 write takes priority over its own read
        s1_awaddr = 4'hC; s1_awvalid = 1; s1_wdata = 32'h1111_2222; s1_wstrb = 4'h3;
        s1_wvalid = 1; s1_araddr = 4'h8; s1_arvalid = 1;
        tick();
        settle();
        chk("pri_m_awvalid", m_awvalid, 1);
        chk("pri_m_arvalid", m_arvalid, 0);
        m_awready = 1; m_wready = 1;
        tick();
        s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = 2'b11; s1_bready = 1;
        settle();
        chk("pri_s1_bresp_decerr", s1_bresp, 2'b11);
        chk("pri_m_arvalid_wb", m_arvalid, 0);
        tick();
        m_bvalid = 0; s1_bready = 0;
        tick();
        settle();
        chk("pri_ar_after_b", m_arvalid, 1);
        m_arready = 1;
        tick();
        s1_arvalid = 0; m_arready = 0; m_rvalid = 1; s1_rready = 1;
        tick();
        m_rvalid = 0; s1_rready = 0;

        // ---- AW accepted at t, W at t+2; then B stall with port 1 waiting
        aw_base = aw_hs_cnt; w_base = w_hs_cnt;
        s0_awaddr = 4'h4; s0_awvalid = 1; s0_wdata = 32'h1234; s0_wvalid = 1;
        tick();
        m_awready = 1; m_wready = 0;
        settle();
        chk("split_s0_awready", s0_awready, 1);
        chk("split_s0_wready", s0_wready, 0);
        tick();
        s0_awvalid = 0; m_awready = 0;
        settle();
        chk("split_m_awvalid_drop", m_awvalid, 0);
        chk("split_m_wvalid", m_wvalid, 1);
        tick();
        settle();
        chk("split_m_bready_t1", m_bready, 0);
        m_wready = 1;
        settle();
        chk("split_s0_wready_t2", s0_wready, 1);
        tick();
        s0_wvalid = 0; m_wready = 0;
        s1_awaddr = 4'h2; s1_awvalid = 1; s1_wdata = 32'hBEEF; s1_wvalid = 1;
        m_awready = 1; m_wready = 1;
        m_bvalid = 1; m_bresp = 2'b00; s0_bready = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("stall_s0_bvalid", s0_bvalid, 1);
            chk("stall_s1_awready", s1_awready, 0);
            chk("stall_m_awvalid", m_awvalid, 0);
            tick();
        end
        s0_bready = 1;
        settle();
        chk("stall_m_bready", m_bready, 1);
        tick();
        m_bvalid = 0; s0_bready = 0;
        settle();
        chk("split_one_aw", aw_hs_cnt - aw_base, 1);
        chk("split_one_w", w_hs_cnt - w_base, 1);
        tick();
        settle();
        chk("wait_s1_m_awaddr", m_awaddr, 4'h2);
        chk("wait_s1_m_wdata", m_wdata, 32'hBEEF);
        tick();
        s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0;
        m_bvalid = 1; s1_bready = 1;
        settle();
        chk("wait_s1_bvalid", s1_bvalid, 1);
        tick();
        m_bvalid = 0; s1_bready = 0;

        // ---- reset while in RR, then a clean read
        s0_araddr = 4'h6; s0_arvalid = 1;
        tick();
        m_arready = 1;
        tick();
        s0_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'h5555; s0_rready = 0;
        settle();
        chk("rst_rr_s0_rvalid_before", s0_rvalid, 1);
        areset = 1;
        tick();
        settle();
        chk("rst_rr_s0_rvalid", s0_rvalid, 0);
        chk("rst_rr_s0_rdata", s0_rdata, 0);
        chk("rst_rr_m_rready", m_rready, 0);
        areset = 0; m_rvalid = 0;
        s0_araddr = 4'hA; s0_arvalid = 1;
        tick();
        m_arready = 1;
        settle();
        chk("post_rst_m_araddr", m_araddr, 4'hA);
        chk("post_rst_s0_arready", s0_arready, 1);
        tick();
        s0_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b00; s0_rready = 1;
        settle();
        chk("post_rst_s0_rdata", s0_rdata, 32'hCAFE_F00D);
        tick();
        m_rvalid = 0; s0_rready = 0;
        settle();
        chk("post_rst_idle", s0_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
AXI_LITE_ARBITER_2TO1 -- requirements
Module: axi_lite_arbiter_2to1

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, giving the address width of all ports; data width is fixed at 32.
REQ-002 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port areset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports sN_axi_awaddr/awprot/awvalid (N=0,1), input, ADDR_WIDTH/3/1 bits: slave-port write address.
REQ-005 SHALL have ports sN_axi_awready, output, 1 bit.
REQ-006 SHALL have ports sN_axi_wdata/wstrb/wvalid, input, 32/4/1 bits, and sN_axi_wready, output, 1 bit.
REQ-007 SHALL have ports sN_axi_bresp/bvalid, output, 2/1 bits, and sN_axi_bready, input, 1 bit.
REQ-008 SHALL have ports sN_axi_araddr/arprot/arvalid, input, ADDR_WIDTH/3/1 bits, and sN_axi_arready, output, 1 bit.
REQ-009 SHALL have ports sN_axi_rdata/rresp/rvalid, output, 32/2/1 bits, and sN_axi_rready, input, 1 bit.
REQ-010 SHALL have ports m_axi_*: the same signal set as one slave port with directions mirrored, driving a single shared AXI4-Lite slave such as the GPIO controller.

Function
REQ-011 SHALL use states IDLE, WR (AW/W forwarding), WB (B wait), RD (AR forwarding) and RR (R wait), with a registered grant index g and a last-grant pointer lg.
REQ-012 SHALL treat port N as requesting a write when sN_awvalid && sN_wvalid, and a read when sN_arvalid.
REQ-013 In IDLE, the granted port SHALL be the requesting port not equal to lg; if only one port requests, that port is granted.
REQ-014 On a grant, lg SHALL be set to g; the state SHALL move to WR if the granted port requests a write, otherwise to RD (write has priority within a port); no port SHALL be forwarded during the IDLE cycle itself.
REQ-015 In WR, m_awaddr/awprot/awvalid and m_wdata/wstrb/wvalid SHALL equal those of port g, and sg_awready/sg_wready SHALL equal m_awready/m_wready, combinationally.
REQ-016 In WR, flags aw_done and w_done SHALL record each completed handshake; once a channel is done, its m_*valid SHALL be 0.
REQ-017 WR SHALL move to WB in the cycle both handshakes have completed, including the case where both complete simultaneously.
REQ-018 In WB, sg_bvalid/bresp SHALL follow m_bvalid/bresp and m_bready SHALL follow sg_bready; on the B handshake the state SHALL return to IDLE.
REQ-019 RD and RR SHALL forward AR and R in the same way as REQ-015 and REQ-018; RD moves to RR on the AR handshake, and RR moves to IDLE on the R handshake.
REQ-020 The non-granted port, and both ports in IDLE, SHALL see all ready/valid outputs at 0 and rdata/rresp/bresp at 0; the m_axi_* valids and readys SHALL be 0 in IDLE.
REQ-021 Only one transaction SHALL be outstanding at a time; the minimum gap between back-to-back transactions is one IDLE cycle.
REQ-022 Slave-side valids SHALL be sampled only in IDLE or while granted; requests from a non-granted port SHALL wait, and no request SHALL be dropped.
REQ-023 Response codes, including SLVERR and DECERR, SHALL pass through unmodified.

Reset
REQ-024 With areset high at a clock edge: state = IDLE, lg = 1 (so port 0 wins the first contention), aw_done = w_done = 0, and every output = 0.
REQ-025 A reset mid-transaction SHALL abandon that transaction with no response issued; the shared slave is reset in the same domain.

Verification
REQ-026 Port 0 writes 0xA5 to address 0x0 while port 1 is idle -> m_awaddr = 0x0 and m_wdata = 0xA5 one cycle after the request; s0_bvalid is seen with bresp = 0; s1 sees no activity.
REQ-027 Both ports request reads in the same cycle immediately after reset -> port 0 is served first, then port 1; 4 alternating contended rounds yield grants 0,1,0,1.
REQ-028 Port 1 has both awvalid+wvalid and arvalid high -> the write completes (B) before AR is forwarded.
REQ-029 Slave accepts AW in cycle t and W in cycle t+2 -> m_awvalid drops after t; WB is entered after t+2; exactly one write occurs.
REQ-030 bready held low for 5 cycles -> bvalid stays high and the state stays WB; the other port stays stalled with awready = 0.
REQ-031 areset asserted in RR -> next cycle all outputs are 0 and the state is IDLE; a new read from port 0 then completes normally.
